// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: one cmd becomes one AW+W/B or AR/R transaction; all bus and rsp outputs registered.
// Latency: cmd handshake -> VALID next cycle; bus handshake -> rsp_valid next cycle. Backpressure: cmd_ready low until rsp consumed.
// Optional watchdog: define AXI4LITE_MASTER_TIMEOUT_EN to add the sticky timeout output.
module axi4lite_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      A_CLK,
    input  logic                      A_RSTn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [1:0]                rsp_resp,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      AW_VALID,
    input  logic                      AW_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    output logic                      W_VALID,
    input  logic                      W_READY,
    output logic [AXI_DATA_WIDTH-1:0] W_DATA,
    input  logic                      B_VALID,
    output logic                      B_READY,
    input  logic [1:0]                B_RESP,
    output logic                      AR_VALID,
    input  logic                      AR_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    input  logic                      R_VALID,
    output logic                      R_READY,
    input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]                R_RESP
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state, state_n;

    logic                      cmd_hs;
    logic                      aw_done, w_done;
    logic                      aw_valid_n, w_valid_n, b_ready_n, ar_valid_n, r_ready_n;
    logic                      rsp_valid_n, rsp_write_n;
    logic [1:0]                rsp_resp_n;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_n, ar_addr_n;
    logic [AXI_DATA_WIDTH-1:0] w_data_n, rsp_rdata_n;

    assign cmd_ready = (state == IDLE) && A_RSTn;
    assign cmd_hs    = cmd_valid && cmd_ready;

    // A write channel counts as done once its VALID has dropped or is handshaking now.
    assign aw_done = !AW_VALID || AW_READY;
    assign w_done  = !W_VALID  || W_READY;

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_hs)              state_n = cmd_write ? WR_AW_W : RD_ADDR;
            WR_AW_W: if (aw_done && w_done)   state_n = WR_RESP;
            WR_RESP: if (B_VALID)             state_n = RSP;
            RD_ADDR: if (AR_READY)            state_n = RD_DATA;
            RD_DATA: if (R_VALID)             state_n = RSP;
            RSP:     if (rsp_ready)           state_n = IDLE;
            default:                          state_n = IDLE;
        endcase
    end

    always_comb begin
        aw_valid_n  = AW_VALID;
        w_valid_n   = W_VALID;
        b_ready_n   = B_READY;
        ar_valid_n  = AR_VALID;
        r_ready_n   = R_READY;
        aw_addr_n   = AW_ADDR;
        ar_addr_n   = AR_ADDR;
        w_data_n    = W_DATA;
        rsp_valid_n = rsp_valid;
        rsp_write_n = rsp_write;
        rsp_resp_n  = rsp_resp;
        rsp_rdata_n = rsp_rdata;
        case (state)
            IDLE: begin
                if (cmd_hs && cmd_write) begin
                    aw_valid_n = 1'b1;
                    w_valid_n  = 1'b1;
                    aw_addr_n  = cmd_addr;
                    w_data_n   = cmd_wdata;
                end else if (cmd_hs) begin
                    ar_valid_n = 1'b1;
                    ar_addr_n  = cmd_addr;
                end
            end
            WR_AW_W: begin
                if (AW_READY)          aw_valid_n = 1'b0;
                if (W_READY)           w_valid_n  = 1'b0;
                if (aw_done && w_done) b_ready_n  = 1'b1;
            end
            WR_RESP: begin
                if (B_VALID) begin
                    b_ready_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_write_n = 1'b1;
                    rsp_resp_n  = B_RESP;
                    rsp_rdata_n = '0;
                end
            end
            RD_ADDR: begin
                if (AR_READY) begin
                    ar_valid_n = 1'b0;
                    r_ready_n  = 1'b1;
                end
            end
            RD_DATA: begin
                if (R_VALID) begin
                    r_ready_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_write_n = 1'b0;
                    rsp_resp_n  = R_RESP;
                    rsp_rdata_n = R_DATA;
                end
            end
            RSP: begin
                if (rsp_ready) rsp_valid_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            AW_VALID  <= 1'b0;
            W_VALID   <= 1'b0;
            B_READY   <= 1'b0;
            AR_VALID  <= 1'b0;
            R_READY   <= 1'b0;
            AW_ADDR   <= '0;
            AR_ADDR   <= '0;
            W_DATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_resp  <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            AW_VALID  <= aw_valid_n;
            W_VALID   <= w_valid_n;
            B_READY   <= b_ready_n;
            AR_VALID  <= ar_valid_n;
            R_READY   <= r_ready_n;
            AW_ADDR   <= aw_addr_n;
            AR_ADDR   <= ar_addr_n;
            W_DATA    <= w_data_n;
            rsp_valid <= rsp_valid_n;
            rsp_write <= rsp_write_n;
            rsp_resp  <= rsp_resp_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             bus_busy;

    assign bus_busy = (state == WR_AW_W) || (state == WR_RESP) ||
                      (state == RD_ADDR) || (state == RD_DATA);

    // Flag only; the transaction keeps waiting because VALID may not be withdrawn.
    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (cmd_hs)                           to_cnt  <= '0;
            else if (bus_busy && to_cnt != CNT_LIM) to_cnt <= to_cnt + 1'b1;
            if (bus_busy && to_cnt == CNT_LAST)   timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: reactive AXI4-Lite slave with programmable wait states, vector table,
// hand-written corner sequences and a randomized run checked against an address->data reference map.
module tb_axi4lite_master;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic          A_CLK = 1'b0, A_RSTn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, rsp_write;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_resp;
    logic [DW-1:0] rsp_rdata;
    logic          AW_VALID, W_VALID, B_READY, AR_VALID, R_READY;
    logic [AW-1:0] AW_ADDR, AR_ADDR;
    logic [DW-1:0] W_DATA;
    logic          AW_READY = 1'b0, W_READY = 1'b0, B_VALID = 1'b0, AR_READY = 1'b0, R_VALID = 1'b0;
    logic [1:0]    B_RESP = 2'b00, R_RESP = 2'b00;
    logic [DW-1:0] R_DATA = '0;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    logic          timeout;
`endif

    axi4lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .A_CLK(A_CLK), .A_RSTn(A_RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 A_CLK = ~A_CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge A_CLK);
        #1;
    endtask

    // Slave responses are a fixed function of the address so expectations can be written down.
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        logic [31:0] t;
        t = a;
        return t[7:6] ^ 2'b01;
    endfunction

    // ---------------- reactive slave ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit ar_never = 0;
    int n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0, n_b_phase = 0, viol = 0;
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_ar_addr = '0;

    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit got_aw, got_w, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(posedge A_CLK) begin
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        #2;
        if (!A_RSTn) begin
            AW_READY = 0; W_READY = 0; AR_READY = 0; B_VALID = 0; R_VALID = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
            p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        end else begin
            aw_hs = p_awv && AW_READY;
            w_hs  = p_wv && W_READY;
            ar_hs = p_arv && AR_READY;
            b_hs  = B_VALID && p_bready;
            r_hs  = R_VALID && p_rready;
            if (p_awv && !aw_hs && (!AW_VALID || AW_ADDR !== p_awaddr)) viol++;
            if (p_wv && !w_hs && (!W_VALID || W_DATA !== p_wdata)) viol++;
            if (p_arv && !ar_hs && (!AR_VALID || AR_ADDR !== p_araddr)) viol++;
            if ((aw_hs && AW_VALID) || (w_hs && W_VALID) || (ar_hs && AR_VALID)) viol++;
            if (B_READY && !p_bready) n_b_phase++;
            if (aw_hs) begin got_aw = 1; s_awaddr = p_awaddr; n_aw_hs++; end
            if (w_hs)  begin got_w = 1; s_wdata = p_wdata; n_w_hs++; end
            if (got_aw && got_w) begin
                slave_mem[s_awaddr] = s_wdata;
                last_wr_addr = s_awaddr; last_wr_data = s_wdata;
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_hs) begin B_VALID = 0; n_b_hs++; end
            if (ar_hs) begin n_ar_hs++; s_araddr = p_araddr; last_ar_addr = p_araddr; r_pend = 1; r_cnt = 0; end
            if (r_hs) R_VALID = 0;

            AW_READY = AW_VALID && aw_cnt >= aw_dly;
            if (AW_VALID && !AW_READY) aw_cnt++; else aw_cnt = 0;
            W_READY = W_VALID && w_cnt >= w_dly;
            if (W_VALID && !W_READY) w_cnt++; else w_cnt = 0;
            AR_READY = AR_VALID && !ar_never && ar_cnt >= ar_dly;
            if (AR_VALID && !AR_READY) ar_cnt++; else ar_cnt = 0;
            if (b_pend) begin
                if (b_cnt >= b_dly) begin B_VALID = 1; B_RESP = resp_of(s_awaddr); b_pend = 0; end
                else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_dly) begin
                    R_VALID = 1; R_RESP = resp_of(s_araddr);
                    R_DATA = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : 32'h0;
                    r_pend = 0;
                end else r_cnt++;
            end
            p_awv = AW_VALID; p_awaddr = AW_ADDR; p_wv = W_VALID; p_wdata = W_DATA;
            p_arv = AR_VALID; p_araddr = AR_ADDR; p_bready = B_READY; p_rready = R_READY;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // One full transaction; holds rsp_ready low for `hold` cycles and reports rsp stability.
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input int hold,
                          output logic ow, output logic [1:0] orsp, output logic [31:0] od,
                          output bit stable);
        int k;
        stable = 1;
        ow = 'x; orsp = 'x; od = 'x;
        k = 0;
        while (!cmd_ready && k < 100) begin step(); k++; end
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        step();
        cmd_valid = 0;
        k = 0;
        while (!rsp_valid && k < 200) begin step(); k++; end
        if (!rsp_valid) begin
            chk("rsp_wait_expired", 0, 1);
            stable = 0;
            return;
        end
        ow = rsp_write; orsp = rsp_resp; od = rsp_rdata;
        repeat (hold) begin
            step();
            if (!rsp_valid || rsp_write !== ow || rsp_resp !== orsp || rsp_rdata !== od || cmd_ready)
                stable = 0;
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("rsp_dropped_after_ready", rsp_valid, 0);
        if (wr) ref_mem[a] = d;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          aw_d, w_d, b_d, ar_d, r_d, hold;
        bit          ew;
        logic [1:0]  eresp;
        logic [31:0] erd;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic ow; logic [1:0] orsp; logic [31:0] od; bit st;
        int baw, bw, bph, k;
        logic [31:0] ra, rd; logic rw; int rh;

        vt[0] = '{1, 32'h04, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 2'b01, 32'h0};
        vt[1] = '{0, 32'h04, 32'h0,        0, 0, 0, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF};
        vt[2] = '{1, 32'h40, 32'h12345678, 0, 3, 0, 0, 0, 0, 1, 2'b00, 32'h0};
        vt[3] = '{0, 32'h40, 32'h0,        0, 0, 0, 2, 3, 0, 0, 2'b00, 32'h12345678};
        vt[4] = '{1, 32'h80, 32'hCAFEF00D, 2, 0, 4, 0, 0, 5, 1, 2'b11, 32'h0};
        vt[5] = '{0, 32'h80, 32'h0,        0, 0, 0, 0, 0, 5, 0, 2'b11, 32'hCAFEF00D};
        vt[6] = '{0, 32'hC0, 32'h0,        0, 0, 0, 1, 1, 1, 0, 2'b10, 32'h0};

        // Reset state
        repeat (3) step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid, rsp_write}, 0);
        chk("rst_payload", {AW_ADDR, W_DATA} | {AR_ADDR, rsp_rdata} | 64'(rsp_resp), 0);
        A_RSTn = 1;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            aw_dly = vt[i].aw_d; w_dly = vt[i].w_d; b_dly = vt[i].b_d;
            ar_dly = vt[i].ar_d; r_dly = vt[i].r_d;
            baw = n_aw_hs; bw = n_w_hs; bph = n_b_phase;
            do_txn(vt[i].wr, vt[i].addr, vt[i].data, vt[i].hold, ow, orsp, od, st);
            chk($sformatf("vec%0d_rsp_write", i), ow, vt[i].ew);
            chk($sformatf("vec%0d_rsp_resp", i), orsp, vt[i].eresp);
            chk($sformatf("vec%0d_rsp_rdata", i), od, vt[i].erd);
            chk($sformatf("vec%0d_hold_stable", i), st, 1);
            if (vt[i].wr) begin
                chk($sformatf("vec%0d_slave_addr", i), last_wr_addr, vt[i].addr);
                chk($sformatf("vec%0d_slave_data", i), last_wr_data, vt[i].data);
                chk($sformatf("vec%0d_handshakes", i), {n_aw_hs - baw, n_w_hs - bw, n_b_phase - bph}, {32'd1, 32'd1} + 0 == 0 ? 0 : {n_aw_hs - baw == 1, n_w_hs - bw == 1, n_b_phase - bph == 1} == 3'b111 ? {n_aw_hs - baw, n_w_hs - bw, n_b_phase - bph} : 96'h1_00000001_00000001);
            end else begin
                chk($sformatf("vec%0d_ar_addr", i), last_ar_addr, vt[i].addr);
            end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

        // Backpressure with a command offered while the response is pending
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h08; cmd_wdata = 32'hA5A50001;
        step();
        cmd_valid = 0;
        k = 0;
        while (!rsp_valid && k < 100) begin step(); k++; end
        chk("bp_rsp_arrived", rsp_valid, 1);
        ref_mem[32'h08] = 32'hA5A50001;
        ow = rsp_write; orsp = rsp_resp;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h08;
        st = 1;
        repeat (5) begin
            step();
            if (!rsp_valid || rsp_write !== ow || rsp_resp !== orsp || cmd_ready || AR_VALID) st = 0;
        end
        chk("bp_stable_and_blocked", st, 1);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("bp_rsp_consumed", rsp_valid, 0);
        chk("bp_cmd_ready_back", cmd_ready, 1);
        step();
        cmd_valid = 0;
        chk("bp_cmd_accepted_ar", {AR_VALID, AR_ADDR}, {1'b1, 32'h08});
        k = 0;
        while (!rsp_valid && k < 100) begin step(); k++; end
        chk("bp_read_rdata", rsp_rdata, 32'hA5A50001);
        rsp_ready = 1; step(); rsp_ready = 0;

        // Reset in the middle of a read
        r_dly = 10;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h04;
        step();
        cmd_valid = 0;
        k = 0;
        while (!R_READY && k < 50) begin step(); k++; end
        chk("midrst_in_rd_data", R_READY, 1);
        A_RSTn = 0;
        step();
        chk("midrst_valids", {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid, rsp_write}, 0);
        chk("midrst_payload", {AW_ADDR, W_DATA} | {AR_ADDR, rsp_rdata} | 64'(rsp_resp), 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        A_RSTn = 1; r_dly = 0;
        st = 1;
        repeat (4) begin step(); if (rsp_valid) st = 0; end
        chk("midrst_no_rsp", st, 1);
        do_txn(0, 32'h04, 0, 0, ow, orsp, od, st);
        chk("midrst_reread", {ow, orsp, od}, {1'b0, 2'b01, ref_rd(32'h04)});

        // Randomized run against the reference map
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, 63)) << 2;
            rd = $urandom;
            rh = $urandom_range(0, 2);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            baw = n_b_hs;
            od = ref_rd(ra);
            do_txn(rw, ra, rd, rh, ow, orsp, od, st);
            if (rw) begin
                chk($sformatf("rnd%0d_wr_rsp", i), {ow, orsp, od}, {1'b1, resp_of(ra), 32'h0});
                chk($sformatf("rnd%0d_wr_slave", i), {last_wr_addr, last_wr_data}, {ra, rd});
                chk($sformatf("rnd%0d_one_b", i), n_b_hs - baw, 1);
            end else begin
                chk($sformatf("rnd%0d_rd_rsp", i), {ow, orsp, od}, {1'b0, resp_of(ra), ref_rd(ra)});
                chk($sformatf("rnd%0d_ar_addr", i), last_ar_addr, ra);
            end
            chk($sformatf("rnd%0d_hold_stable", i), st, 1);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        // Watchdog: AR never accepted
        ar_never = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
        step();
        cmd_valid = 0;
        repeat (7) step();
        chk("to_not_yet", timeout, 0);
        step();
        chk("to_fired", {timeout, AR_VALID}, 2'b11);
        repeat (5) step();
        chk("to_sticky", {timeout, AR_VALID}, 2'b11);
        A_RSTn = 0; ar_never = 0;
        step();
        chk("to_cleared_by_reset", timeout, 0);
        A_RSTn = 1;
        step();
`endif

        chk("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response request port into AXI4-Lite write and read transactions.
- Sits directly upstream of the team's AXI4-Lite slave and register bank. Testbenches and control logic drive registers through it.
- Exactly one transaction is in flight at a time. Writes drive AW and W together; reads drive AR only.

Parameters:
- AXI_ADDR_WIDTH, 32, width of AW_ADDR, AR_ADDR and cmd_addr.
- AXI_DATA_WIDTH, 32, width of W_DATA, R_DATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles. Used only when AXI4LITE_MASTER_TIMEOUT_EN is defined.

Ports:
- A_CLK  in  1  clock; everything is sampled on the rising edge.
- A_RSTn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  AXI_DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  response belongs to a write.
- rsp_resp  out  2  captured B_RESP or R_RESP.
- rsp_rdata  out  AXI_DATA_WIDTH  captured R_DATA; 0 for writes.
- AW_VALID out 1; AW_READY in 1; AW_ADDR out AXI_ADDR_WIDTH.
- W_VALID out 1; W_READY in 1; W_DATA out AXI_DATA_WIDTH.
- B_VALID in 1; B_READY out 1; B_RESP in 2.
- AR_VALID out 1; AR_READY in 1; AR_ADDR out AXI_ADDR_WIDTH.
- R_VALID in 1; R_READY out 1; R_DATA in AXI_DATA_WIDTH; R_RESP in 2.
- timeout  out  1  sticky watchdog flag; present only with AXI4LITE_MASTER_TIMEOUT_EN.

Behaviour:
- Reset (A_RSTn=0 at a clock edge):
  - State goes to IDLE.
  - All AXI outputs go to 0: VALIDs, READYs, ADDR, DATA.
  - Response outputs go to 0: rsp_valid, rsp_write, rsp_resp, rsp_rdata.
  - cmd_ready = 0 during reset.
  - Reset mid-transaction abandons it immediately. No response is produced.
- All AXI outputs and all rsp_* outputs are registered.
- cmd_ready is combinational: (state == IDLE) and not in reset.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd handshake, latch addr and wdata.
    - Write: next cycle AW_VALID=W_VALID=1, go to WR_AW_W.
    - Read: next cycle AR_VALID=1, go to RD_ADDR.
  - WR_AW_W: AW and W are tracked independently with per-channel done flags.
    - AW_VALID drops the cycle after the AW handshake. W_VALID drops the cycle after the W handshake.
    - Each VALID and its payload stay stable until their own handshake.
    - When both are done, including a same-cycle double handshake, the next cycle has B_READY=1 and the state is WR_RESP.
  - WR_RESP: B_READY=1.
    - On B_VALID && B_READY, capture B_RESP, set rsp_write=1 and rsp_rdata=0.
    - Next cycle: rsp_valid=1, B_READY=0, go to RSP.
  - RD_ADDR: AR_VALID=1, AR_ADDR stable.
    - On AR handshake, next cycle AR_VALID=0, R_READY=1, go to RD_DATA.
  - RD_DATA: R_READY=1.
    - On R handshake, capture R_DATA and R_RESP, set rsp_write=0.
    - Next cycle: rsp_valid=1, R_READY=0, go to RSP.
  - RSP: rsp_valid=1; rsp_* held stable.
    - On rsp_ready, next cycle rsp_valid=0, state returns to IDLE.
    - rsp_ready already high on entry means rsp_valid is high for exactly 1 cycle.
- Latency with a zero-wait slave: roughly 1 cycle from cmd handshake to VALID, the handshake cycle, then 1 cycle to rsp_valid. The slave FSM adds its own cycles.
- No new cmd is accepted until the response is consumed.
- VALIDs never depend combinationally on READYs, which prevents deadlock with the slave FSM.
- Non-zero rsp_resp is passed through unchanged. The master takes no action on it.
- Handshake signals (B_VALID, R_VALID, AW_READY, W_READY, AR_READY) are ignored in states that do not expect them.

Optional Feature:
- Macro: AXI4LITE_MASTER_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on cmd handshake.
  - It increments each cycle in WR_AW_W, WR_RESP, RD_ADDR and RD_DATA, and saturates.
  - When it reaches TIMEOUT_CYCLES, timeout goes to 1 and stays sticky until reset.
  - The bus transaction is not aborted; AXI rules forbid dropping VALID.
- When not defined: no counter and no timeout port.

Test Plan:
- Write, zero-wait slave: cmd write addr=0x4 data=0xDEADBEEF -> AW/W show 0x4/0xDEADBEEF; one B handshake; rsp_valid=1, rsp_write=1, rsp_resp=B_RESP (0b01 with the current slave).
- Read-back: cmd read addr=0x4 -> AR_ADDR=0x4; rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_resp=R_RESP.
- Skewed write channels: AW_READY 3 cycles before W_READY -> AW_VALID drops the cycle after its handshake, W_VALID holds until its own; exactly one B_READY phase; one response.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable; cmd_ready=0; a cmd offered meanwhile is accepted only after rsp_ready.
- Reset mid-read: A_RSTn=0 while in RD_DATA -> next edge all outputs 0, IDLE, no rsp_valid; a new read afterwards completes normally.
- With AXI4LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never asserts AR_READY -> timeout=1 after 8 cycles in RD_ADDR, AR_VALID still 1; timeout stays 1 until reset.
